// File: rtl/rgb_pwm_ctrl.sv
// rtl/rgb_pwm_ctrl.sv - three-channel RGB LED PWM controller with jump/fade duty commands
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (accepted when both high on a rising edge)
//   cmd_chan              0 = R, 1 = G, 2 = B, 3 = all three
//   cmd_duty              target duty 0..255
//   cmd_fade              1 = ramp one step per PWM period, 0 = jump immediately
//   pwm_r/pwm_g/pwm_b     registered PWM outputs to the RGB LED driver
//   busy                  registered OR of the per-channel ramp states
//   period_start          one-clock pulse on the first cycle of each PWM period
module rgb_pwm_ctrl #(
    parameter int PWM_DIV = 187
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_chan,
    input  logic [7:0] cmd_duty,
    input  logic       cmd_fade,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b,
    output logic       busy,
    output logic       period_start
);

    // A divider of 0 still needs a one-bit prescaler register.
    localparam int PW = (PWM_DIV < 1) ? 1 : $clog2(PWM_DIV + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    logic [PW-1:0] presc;
    logic [7:0]    cnt;
    logic          tick;
    logic          bnd;
    logic          acc;
    logic [2:0]    hit;

    logic [7:0]    tgt [3];
    logic [7:0]    cur [3];
    logic [7:0]    act [3];
    state_t        st  [3];

    function automatic logic [7:0] step_toward(input logic [7:0] c, input logic [7:0] t);
        return (c < t) ? c + 8'd1 : c - 8'd1;
    endfunction

    assign tick = (presc == PW'(PWM_DIV));
    assign bnd  = tick && (cnt == 8'd255);
    assign acc  = cmd_valid && cmd_ready;

    always_comb begin
        hit = '0;
        for (int i = 0; i < 3; i++) begin
            hit[i] = acc && ((cmd_chan == 2'(i)) || (cmd_chan == 2'd3));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc        <= '0;
            cnt          <= '0;
            cmd_ready    <= 1'b0;
            period_start <= 1'b0;
            busy         <= 1'b0;
            pwm_r        <= 1'b0;
            pwm_g        <= 1'b0;
            pwm_b        <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                tgt[i] <= '0;
                cur[i] <= '0;
                act[i] <= '0;
                st[i]  <= IDLE;
            end
        end else begin
            cmd_ready    <= 1'b1;
            presc        <= tick ? '0 : presc + 1'b1;
            period_start <= bnd;
            if (tick) begin
                cnt <= cnt + 8'd1;
            end

            for (int i = 0; i < 3; i++) begin
                // act always samples the pre-update cur, so a command landing on the
                // boundary only becomes visible one period later.
                if (bnd) begin
                    act[i] <= cur[i];
                end
                // A command wins over the boundary ramp step for its channel.
                if (hit[i]) begin
                    tgt[i] <= cmd_duty;
                    if (cmd_fade) begin
                        st[i] <= (cmd_duty != cur[i]) ? RAMP : IDLE;
                    end else begin
                        cur[i] <= cmd_duty;
                        st[i]  <= IDLE;
                    end
                end else if (bnd && (st[i] == RAMP)) begin
                    cur[i] <= step_toward(cur[i], tgt[i]);
                    if (step_toward(cur[i], tgt[i]) == tgt[i]) begin
                        st[i] <= IDLE;
                    end
                end
            end

            pwm_r <= (act[0] > cnt);
            pwm_g <= (act[1] > cnt);
            pwm_b <= (act[2] > cnt);
            busy  <= (st[0] == RAMP) || (st[1] == RAMP) || (st[2] == RAMP);
        end
    end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// tb/tb_rgb_pwm_ctrl.sv - directed self-checking bench for rgb_pwm_ctrl with a 256-clock PWM period
module tb_rgb_pwm_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_chan = 2'd0;
    logic [7:0] cmd_duty = 8'd0;
    logic       cmd_fade = 1'b0;
    logic       pwm_r;
    logic       pwm_g;
    logic       pwm_b;
    logic       busy;
    logic       period_start;

    int n_cmp = 0;
    int n_err = 0;

    rgb_pwm_ctrl #(.PWM_DIV(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_chan     (cmd_chan),
        .cmd_duty     (cmd_duty),
        .cmd_fade     (cmd_fade),
        .pwm_r        (pwm_r),
        .pwm_g        (pwm_g),
        .pwm_b        (pwm_b),
        .busy         (busy),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ps(input string tag);
        int found;
        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            @(negedge clk);
            if (period_start) found = 1;
        end
        if (found == 0) check_eq({tag, "_timeout"}, found, 1);
    endtask

    // Counts high samples over one full period starting at the period_start cycle;
    // also reports busy on the first two cycles of that period.
    task automatic count_period(input string tag, output int hr, output int hg, output int hb,
                                output int b0, output int b1);
        wait_ps(tag);
        hr = int'(pwm_r);
        hg = int'(pwm_g);
        hb = int'(pwm_b);
        b0 = int'(busy);
        b1 = 0;
        for (int i = 1; i < 256; i++) begin
            @(negedge clk);
            hr += int'(pwm_r);
            hg += int'(pwm_g);
            hb += int'(pwm_b);
            if (i == 1) b1 = int'(busy);
        end
    endtask

    task automatic send_cmd(input logic [1:0] ch, input logic [7:0] d, input logic f);
        repeat (2) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_chan  = ch;
        cmd_duty  = d;
        cmd_fade  = f;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    int hr, hg, hb, b0, b1, n;
    int ramp_up_r[4]   = '{10, 11, 12, 13};
    int collide_r[5]   = '{15, 15, 14, 13, 12};

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_pwm_r", int'(pwm_r), 0);
        check_eq("rst_pwm_g", int'(pwm_g), 0);
        check_eq("rst_pwm_b", int'(pwm_b), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_period_start", int'(period_start), 0);
        check_eq("rst_cmd_ready", int'(cmd_ready), 0);

        // Release: ready on first clock, first boundary 256 clocks later
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            n++;
            if (n == 1) check_eq("rel_cmd_ready", int'(cmd_ready), 1);
            if (period_start) break;
        end
        check_eq("rel_first_period_start", n, 256);

        // Jump R to 64
        send_cmd(2'd0, 8'd64, 1'b0);
        count_period("jump", hr, hg, hb, b0, b1);
        check_eq("jump_r_high", hr, 64);
        check_eq("jump_g_high", hg, 0);
        check_eq("jump_b_high", hb, 0);

        // Fade G from 0 to 4
        send_cmd(2'd1, 8'd4, 1'b1);
        for (int k = 0; k < 5; k++) begin
            count_period("ramp", hr, hg, hb, b0, b1);
            check_eq($sformatf("ramp_g_high_p%0d", k), hg, k);
            check_eq($sformatf("ramp_r_high_p%0d", k), hr, 64);
            if (k == 0) check_eq("ramp_busy_on", b0, 1);
            if (k == 3) begin
                check_eq("ramp_busy_at_last_step", b0, 1);
                check_eq("ramp_busy_after_last_step", b1, 0);
            end
            if (k == 4) check_eq("ramp_busy_idle", b0, 0);
        end

        // All channels to 255
        send_cmd(2'd3, 8'd255, 1'b0);
        count_period("all", hr, hg, hb, b0, b1);
        check_eq("all_r_high", hr, 255);
        check_eq("all_g_high", hg, 255);
        check_eq("all_b_high", hb, 255);
        check_eq("all_busy", b0, 0);

        // Boundary collision: R ramps 10 -> 20, retarget to 12 on the boundary cycle at cur=15
        send_cmd(2'd0, 8'd10, 1'b0);
        send_cmd(2'd0, 8'd20, 1'b1);
        for (int k = 0; k < 4; k++) begin
            count_period("coll_up", hr, hg, hb, b0, b1);
            check_eq($sformatf("coll_up_r_high_p%0d", k), hr, ramp_up_r[k]);
        end
        wait_ps("coll_sync");
        repeat (255) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_chan  = 2'd0;
        cmd_duty  = 8'd12;
        cmd_fade  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            count_period("coll_dn", hr, hg, hb, b0, b1);
            check_eq($sformatf("coll_dn_r_high_p%0d", k), hr, collide_r[k]);
            if (k == 0) check_eq("coll_g_high", hg, 255);
            if (k == 3) begin
                check_eq("coll_busy_at_last_step", b0, 1);
                check_eq("coll_busy_after_last_step", b1, 0);
            end
            if (k == 4) check_eq("coll_busy_idle", b0, 0);
        end

        // Reset in the middle of a B fade 255 -> 0
        send_cmd(2'd2, 8'd0, 1'b1);
        repeat (300) @(negedge clk);
        check_eq("midrst_busy_before", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_pwm_r", int'(pwm_r), 0);
        check_eq("midrst_pwm_g", int'(pwm_g), 0);
        check_eq("midrst_pwm_b", int'(pwm_b), 0);
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_cmd_ready", int'(cmd_ready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_period("postrst", hr, hg, hb, b0, b1);
        check_eq("postrst_r_high", hr, 0);
        check_eq("postrst_g_high", hg, 0);
        check_eq("postrst_b_high", hb, 0);
        check_eq("postrst_busy", b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_ctrl.md
RGB_PWM_CTRL -- requirements
Module: rgb_pwm_ctrl

Interface
REQ-001 The block SHALL have one parameter: PWM_DIV, default 187, prescaler terminal count; one PWM tick every PWM_DIV+1 clocks (about 1 kHz PWM period at 48 MHz).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: command present.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid and cmd_ready are both high on a clock edge.
REQ-006 The block SHALL have port cmd_chan, input, 2 bits: 0 = R, 1 = G, 2 = B, 3 = all three channels.
REQ-007 The block SHALL have port cmd_duty, input, 8 bits: target duty, 0..255.
REQ-008 The block SHALL have port cmd_fade, input, 1 bit: 1 = ramp to target, 0 = jump to target.
REQ-009 The block SHALL have ports pwm_r, pwm_g and pwm_b, outputs, 1 bit each, registered: they feed RGB0PWM, RGB1PWM and RGB2PWM of the RGB LED driver.
REQ-010 The block SHALL have port busy, output, 1 bit: high while any channel is in RAMP.
REQ-011 The block SHALL have port period_start, output, 1 bit: one-clock pulse at each PWM period boundary.

Function
REQ-012 The prescaler SHALL count 0..PWM_DIV, wrap to 0, and assert an internal tick on the cycle it equals PWM_DIV.
REQ-013 An 8-bit cnt SHALL increment on each tick and wrap 255->0.
REQ-014 The boundary event E SHALL be tick AND cnt==255; period_start SHALL be registered E, so it is high for the first cycle with cnt==0.
REQ-015 Each channel SHALL hold three 8-bit registers: tgt (target), cur (working value) and act (active duty); plus a state, IDLE or RAMP.
REQ-016 On E, act SHALL load the pre-update value of cur; duty changes therefore take effect only at period boundaries, with no glitches mid-period.
REQ-017 Each cycle, pwm_x SHALL be registered (act_x > cnt): duty 0 gives a constant low output, and duty 255 gives 255 of 256 ticks high.
REQ-018 A command accepted with cmd_fade=0 SHALL set tgt=cur=cmd_duty for the addressed channel(s), with state IDLE.
REQ-019 A command accepted with cmd_fade=1 SHALL set tgt=cmd_duty; the state becomes RAMP if cmd_duty != cur, else IDLE.
REQ-020 In RAMP on E, cur SHALL step by 1 toward tgt; when the stepped value equals tgt, the state SHALL return to IDLE in the same cycle.
REQ-021 If a command is accepted in the same cycle as E for a channel, the command update SHALL take precedence, with no ramp step for that channel; act still latches the old cur.
REQ-022 A command to a channel already in RAMP SHALL retarget it; a ramp in progress is never queued.
REQ-023 cmd_ready SHALL be a register: 0 during reset, and 1 in every cycle after rst deasserts; commands are never back-pressured otherwise.
REQ-024 busy SHALL be the registered OR of the RAMP states.
REQ-025 Commands with cmd_chan=3 SHALL update all three channels identically in one cycle.

Reset
REQ-026 While rst is high, the prescaler, cnt, every tgt, cur and act, and all outputs SHALL clear to 0, with all states IDLE.
REQ-027 The first clock after rst falls SHALL present cmd_ready=1 and a prescaler count of 0.
REQ-028 A reset asserted mid-ramp or mid-period SHALL abort everything; pwm_x SHALL be 0 in the cycle after the rst edge, and no stale duty SHALL survive.

Verification (PWM_DIV=0, i.e. a 256-clock period)
REQ-029 Reset check: hold rst high for 3 clocks -> pwm_r/g/b=0, busy=0, period_start=0, cmd_ready=0; after release, cmd_ready=1 with the first period_start 256 clocks later.
REQ-030 Jump check: chan=0, duty=64, fade=0 -> pwm_r is high exactly 64 consecutive clocks per period starting at the first period_start after acceptance; pwm_g and pwm_b stay 0.
REQ-031 Ramp check: chan=1, duty=4, fade=1 from 0 -> busy=1; pwm_g high-counts over successive periods are 0,1,2,3,4; busy falls in the cycle after the 4th boundary step.
REQ-032 All-channel check: chan=3, duty=255, fade=0 -> all outputs high 255 of 256 clocks per period, low only in the cnt==255 slot (offset one clock by the registered output).
REQ-033 Boundary collision check: during a ramp of R from 10 to 20 with cur=15, issue a fade=1 command with duty=12 on the E cycle -> no step that period, cur stays 15, then cur goes 14, 13, 12, IDLE.
REQ-034 Reset mid-ramp check: assert rst during an active ramp -> next cycle all outputs 0, busy=0; after release, pwm stays 0 until a new command.
